// File: rtl/cache_ri_fill.sv
// Miss / uncached engine behind the cache read-write stage.
// Fills a 16-word line over a burst master, or does one IO beat.
module cache_ri_fill #(
  parameter int SIZE = 8192,
  parameter logic [3:0] CMD_NOP = 4'd0,
  parameter logic [3:0] CMD_RB = 4'd1,
  parameter logic [3:0] CMD_IORW = 4'd2,
  parameter logic [3:0] CMD_HCC = 4'd3,
  localparam int DW = $clog2(SIZE / 16),
  localparam int TW = DW - 4,
  localparam int TAG_WIDTH = 30 - DW
) (
  input  logic          clk,
  input  logic          rest,
  input  logic [3:0]    ri_cmd,
  input  logic          ri_cmd_valid,
  output logic          ri_cmd_ready,
  output logic [31:0]   ri_rsp_data,
  input  logic          ri_isCacheEnable,
  input  logic [31:0]   req_address,
  input  logic [3:0]    req_byteEnable,
  input  logic          req_read,
  input  logic          req_write,
  input  logic [31:0]   req_writeData,
  output logic [31:0]   m0_address,
  output logic [4:0]    m0_burstCount,
  output logic          m0_read,
  output logic          m0_write,
  output logic [3:0]    m0_byteEnable,
  output logic [31:0]   m0_writeData,
  input  logic          m0_waitRequest,
  input  logic [31:0]   m0_readData,
  input  logic          m0_readDataValid,
  output logic [TW-1:0] tag_ri_readAddress,
  input  logic          tag_ri_isHaveFreeBlock,
  input  logic [1:0]    tag_ri_freeBlockNum,
  output logic [TW-1:0] tag_ri_writeAddress,
  output logic [1:0]    tag_ri_writeChannel,
  output logic          tag_ri_writeEnable,
  output logic [31:0]   tag_ri_writeData,
  output logic [DW-1:0] data_ri_writeAddress,
  output logic [1:0]    data_ri_rwChannel,
  output logic [3:0]    data_ri_writeByteEnable,
  output logic          data_ri_writeEnable,
  output logic [31:0]   data_ri_writeData,
  output logic [DW-2:0] dre_ri_writeAddress,
  output logic [1:0]    dre_ri_writeChannel,
  output logic          dre_ri_writeEnable,
  output logic [7:0]    dre_ri_writeData
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_RD_REQ = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_MERGE = 3'd4;
  localparam logic [2:0] S_IO_REQ = 3'd5;
  localparam logic [2:0] S_IO_WAIT = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  typedef struct packed {
    logic          ready;
    logic [31:0]   rsp;
    logic [31:0]   m_addr;
    logic [4:0]    m_burst;
    logic          m_rd;
    logic          m_wr;
    logic [3:0]    m_be;
    logic [31:0]   m_wd;
    logic [TW-1:0] t_raddr;
    logic [TW-1:0] t_waddr;
    logic [1:0]    t_ch;
    logic          t_we;
    logic [31:0]   t_wd;
    logic [DW-1:0] d_addr;
    logic [1:0]    d_ch;
    logic [3:0]    d_be;
    logic          d_we;
    logic [31:0]   d_wd;
    logic [DW-2:0] r_addr;
    logic [1:0]    r_ch;
    logic          r_we;
  } out_t;

  out_t        o_d, o_q;
  logic [2:0]  state_d, state_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [1:0]  rr_d, rr_q;
  logic [1:0]  vic_d, vic_q;
  logic [31:0] rsp_d, rsp_q;
  logic [31:2] addr_d, addr_q;
  logic [3:0]  be_d, be_q;
  logic [31:0] wd_d, wd_q;
  logic        wr_d, wr_q;
  logic        io_go;
  logic        fin;
  logic [31:0] merged;

  wire [TW-1:0] set_idx = addr_q[DW+1:6];
  wire [3:0]    word = addr_q[5:2];
  wire [31:0]   tag_word =
    {1'b1, {(31-TAG_WIDTH){1'b0}}, addr_q[31:DW+2]};

  assign ri_cmd_ready = o_q.ready;
  assign ri_rsp_data = o_q.rsp;
  assign m0_address = o_q.m_addr;
  assign m0_burstCount = o_q.m_burst;
  assign m0_read = o_q.m_rd;
  assign m0_write = o_q.m_wr;
  assign m0_byteEnable = o_q.m_be;
  assign m0_writeData = o_q.m_wd;
  assign tag_ri_readAddress = o_q.t_raddr;
  assign tag_ri_writeAddress = o_q.t_waddr;
  assign tag_ri_writeChannel = o_q.t_ch;
  assign tag_ri_writeEnable = o_q.t_we;
  assign tag_ri_writeData = o_q.t_wd;
  assign data_ri_writeAddress = o_q.d_addr;
  assign data_ri_rwChannel = o_q.d_ch;
  assign data_ri_writeByteEnable = o_q.d_be;
  assign data_ri_writeEnable = o_q.d_we;
  assign data_ri_writeData = o_q.d_wd;
  assign dre_ri_writeAddress = o_q.r_addr;
  assign dre_ri_writeChannel = o_q.r_ch;
  assign dre_ri_writeEnable = o_q.r_we;
  assign dre_ri_writeData = 8'hFF;

  // Store bytes overlay the filled word for the returned read data.
  always_comb begin
    merged = rsp_q;
    for (int i = 0; i < 4; i++)
      if (be_q[i]) merged[8*i +: 8] = wd_q[8*i +: 8];
  end

  // Next-state, next-output and datapath for the fill/IO sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rr_d = rr_q;
    vic_d = vic_q;
    rsp_d = rsp_q;
    addr_d = addr_q;
    be_d = be_q;
    wd_d = wd_q;
    wr_d = wr_q;
    io_go = 1'b0;
    fin = 1'b0;
    o_d = o_q;
    o_d.ready = 1'b0;
    o_d.rsp = '0;
    o_d.t_we = 1'b0;
    o_d.d_we = 1'b0;
    o_d.r_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ri_cmd_valid) begin
          addr_d = req_address[31:2];
          be_d = req_byteEnable;
          wd_d = req_writeData;
          wr_d = req_write;
          cnt_d = '0;
          rsp_d = '0;
          o_d.t_raddr = req_address[DW+1:6];
          case (ri_cmd)
            CMD_RB: begin
              if (ri_isCacheEnable) state_d = S_LOOKUP;
              else io_go = 1'b1;
            end
            CMD_IORW: io_go = 1'b1;
            CMD_HCC, CMD_NOP: fin = 1'b1;
            default: fin = 1'b1;
          endcase
          if (io_go) begin
            state_d = S_IO_REQ;
            o_d.m_rd = req_read;
            o_d.m_wr = req_write;
            o_d.m_addr = req_address;
            o_d.m_burst = 5'd1;
            o_d.m_be = req_byteEnable;
            o_d.m_wd = req_writeData;
          end
        end
      end
      S_LOOKUP: begin
        if (tag_ri_isHaveFreeBlock) begin
          vic_d = tag_ri_freeBlockNum;
        end else begin
          vic_d = rr_q;
          rr_d = rr_q + 2'd1;
        end
        state_d = S_RD_REQ;
        o_d.m_rd = 1'b1;
        o_d.m_addr = {addr_q[31:6], 6'b0};
        o_d.m_burst = 5'd16;
        o_d.m_be = 4'hF;
        o_d.m_wd = wd_q;
      end
      S_RD_REQ: begin
        if (!m0_waitRequest) begin
          o_d.m_rd = 1'b0;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m0_readDataValid) begin
          o_d.d_we = 1'b1;
          o_d.d_addr = {set_idx, cnt_q};
          o_d.d_ch = vic_q;
          o_d.d_be = 4'hF;
          o_d.d_wd = m0_readData;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == word) rsp_d = m0_readData;
          if (cnt_q[0]) begin
            o_d.r_we = 1'b1;
            o_d.r_addr = {set_idx, cnt_q[3:1]};
            o_d.r_ch = vic_q;
          end
          if (cnt_q == 4'd15) begin
            o_d.t_we = 1'b1;
            o_d.t_waddr = set_idx;
            o_d.t_ch = vic_q;
            o_d.t_wd = tag_word;
            if (wr_q) state_d = S_MERGE;
            else fin = 1'b1;
          end
        end
      end
      S_MERGE: begin
        o_d.d_we = 1'b1;
        o_d.d_addr = {set_idx, word};
        o_d.d_ch = vic_q;
        o_d.d_be = be_q;
        o_d.d_wd = wd_q;
        rsp_d = merged;
        fin = 1'b1;
      end
      S_IO_REQ: begin
        if (!m0_waitRequest) begin
          o_d.m_rd = 1'b0;
          o_d.m_wr = 1'b0;
          if (wr_q) fin = 1'b1;
          else state_d = S_IO_WAIT;
        end
      end
      S_IO_WAIT: begin
        if (m0_readDataValid) begin
          rsp_d = m0_readData;
          fin = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d = S_DONE;
      o_d.ready = 1'b1;
      o_d.rsp = rsp_d;
    end
  end

  // State and registered outputs; reset abandons any burst at once.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      rr_q <= '0;
      vic_q <= '0;
      rsp_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wd_q <= '0;
      wr_q <= 1'b0;
      o_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      vic_q <= vic_d;
      rsp_q <= rsp_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wd_q <= wd_d;
      wr_q <= wr_d;
      o_q <= o_d;
    end
  end

endmodule

// File: tb/tb_cache_ri_fill.sv
// Directed bench for cache_ri_fill.
// Slave and tag responses are driven by hand.
module tb_cache_ri_fill;

  localparam logic [3:0] C_NOP = 4'd0;
  localparam logic [3:0] C_RB = 4'd1;
  localparam logic [3:0] C_IORW = 4'd2;

  logic        clk = 1'b0;
  logic        rest;
  logic [3:0]  ri_cmd;
  logic        ri_cmd_valid;
  logic        ri_cmd_ready;
  logic [31:0] ri_rsp_data;
  logic        ri_isCacheEnable;
  logic [31:0] req_address;
  logic [3:0]  req_byteEnable;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_writeData;
  logic [31:0] m0_address;
  logic [4:0]  m0_burstCount;
  logic        m0_read;
  logic        m0_write;
  logic [3:0]  m0_byteEnable;
  logic [31:0] m0_writeData;
  logic        m0_waitRequest;
  logic [31:0] m0_readData;
  logic        m0_readDataValid;
  logic [4:0]  tag_ri_readAddress;
  logic        tag_ri_isHaveFreeBlock;
  logic [1:0]  tag_ri_freeBlockNum;
  logic [4:0]  tag_ri_writeAddress;
  logic [1:0]  tag_ri_writeChannel;
  logic        tag_ri_writeEnable;
  logic [31:0] tag_ri_writeData;
  logic [8:0]  data_ri_writeAddress;
  logic [1:0]  data_ri_rwChannel;
  logic [3:0]  data_ri_writeByteEnable;
  logic        data_ri_writeEnable;
  logic [31:0] data_ri_writeData;
  logic [7:0]  dre_ri_writeAddress;
  logic [1:0]  dre_ri_writeChannel;
  logic        dre_ri_writeEnable;
  logic [7:0]  dre_ri_writeData;

  always #5 clk = ~clk;

  cache_ri_fill dut (
    .clk(clk), .rest(rest),
    .ri_cmd(ri_cmd), .ri_cmd_valid(ri_cmd_valid),
    .ri_cmd_ready(ri_cmd_ready), .ri_rsp_data(ri_rsp_data),
    .ri_isCacheEnable(ri_isCacheEnable),
    .req_address(req_address), .req_byteEnable(req_byteEnable),
    .req_read(req_read), .req_write(req_write),
    .req_writeData(req_writeData),
    .m0_address(m0_address), .m0_burstCount(m0_burstCount),
    .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteEnable(m0_byteEnable), .m0_writeData(m0_writeData),
    .m0_waitRequest(m0_waitRequest), .m0_readData(m0_readData),
    .m0_readDataValid(m0_readDataValid),
    .tag_ri_readAddress(tag_ri_readAddress),
    .tag_ri_isHaveFreeBlock(tag_ri_isHaveFreeBlock),
    .tag_ri_freeBlockNum(tag_ri_freeBlockNum),
    .tag_ri_writeAddress(tag_ri_writeAddress),
    .tag_ri_writeChannel(tag_ri_writeChannel),
    .tag_ri_writeEnable(tag_ri_writeEnable),
    .tag_ri_writeData(tag_ri_writeData),
    .data_ri_writeAddress(data_ri_writeAddress),
    .data_ri_rwChannel(data_ri_rwChannel),
    .data_ri_writeByteEnable(data_ri_writeByteEnable),
    .data_ri_writeEnable(data_ri_writeEnable),
    .data_ri_writeData(data_ri_writeData),
    .dre_ri_writeAddress(dre_ri_writeAddress),
    .dre_ri_writeChannel(dre_ri_writeChannel),
    .dre_ri_writeEnable(dre_ri_writeEnable),
    .dre_ri_writeData(dre_ri_writeData)
  );

  int checks = 0;
  int failures = 0;

  logic        clr = 1'b0;
  int          dw, dre, tw, rdy, wcyc;
  logic [3:0]  chs;
  logic [31:0] wword [16];
  logic [8:0]  last_da;
  logic [3:0]  last_be;
  logic [31:0] last_dd;
  logic [7:0]  last_ra;
  logic [4:0]  last_ta;
  logic [1:0]  last_tc;
  logic [31:0] last_td;
  logic [31:0] rsp_last;
  logic [31:0] cap_addr;
  logic [4:0]  cap_burst;

  // Observer: tallies strobes, one count per cycle a strobe is high.
  always @(negedge clk) begin
    if (clr) begin
      dw = 0; dre = 0; tw = 0; rdy = 0; wcyc = 0; chs = '0;
    end else begin
      if (data_ri_writeEnable) begin
        dw++;
        chs[data_ri_rwChannel] = 1'b1;
        wword[data_ri_writeAddress[3:0]] = data_ri_writeData;
        last_da = data_ri_writeAddress;
        last_be = data_ri_writeByteEnable;
        last_dd = data_ri_writeData;
      end
      if (dre_ri_writeEnable) begin
        dre++;
        last_ra = dre_ri_writeAddress;
      end
      if (tag_ri_writeEnable) begin
        tw++;
        last_ta = tag_ri_writeAddress;
        last_tc = tag_ri_writeChannel;
        last_td = tag_ri_writeData;
      end
      if (ri_cmd_ready) begin
        rdy++;
        rsp_last = ri_rsp_data;
      end
      if (m0_write) wcyc++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ri_cmd_ready && n < 60) begin
      step();
      n++;
    end
    chk("ready_timeout", {31'b0, ri_cmd_ready}, 32'd1);
    ri_cmd_valid = 1'b0;
    step();
  endtask

  task automatic wait_mread();
    int n = 0;
    while (!m0_read && n < 20) begin
      step();
      n++;
    end
    chk("m0_read_timeout", {31'b0, m0_read}, 32'd1);
    cap_addr = m0_address;
    cap_burst = m0_burstCount;
  endtask

  task automatic fill(input logic [31:0] a, input logic fr,
                      input logic [1:0] fn, input logic wr,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] base, input int sp,
                      input logic [31:0] spv);
    clear();
    req_address = a;
    req_read = !wr;
    req_write = wr;
    req_byteEnable = be;
    req_writeData = wd;
    tag_ri_isHaveFreeBlock = fr;
    tag_ri_freeBlockNum = fn;
    ri_isCacheEnable = 1'b1;
    ri_cmd = C_RB;
    ri_cmd_valid = 1'b1;
    wait_mread();
    step();
    for (int i = 0; i < 16; i++) begin
      m0_readDataValid = 1'b1;
      m0_readData = (i == sp) ? spv : base + i;
      step();
    end
    m0_readDataValid = 1'b0;
    wait_ready();
  endtask

  logic [1:0] exp_way [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rest = 1'b1;
    ri_cmd = C_NOP;
    ri_cmd_valid = 1'b0;
    ri_isCacheEnable = 1'b1;
    req_address = '0;
    req_byteEnable = '0;
    req_read = 1'b0;
    req_write = 1'b0;
    req_writeData = '0;
    m0_waitRequest = 1'b0;
    m0_readData = '0;
    m0_readDataValid = 1'b0;
    tag_ri_isHaveFreeBlock = 1'b0;
    tag_ri_freeBlockNum = '0;
    repeat (3) step();
    chk("reset_strobes", {26'b0, ri_cmd_ready, m0_read, m0_write,
        data_ri_writeEnable, tag_ri_writeEnable, dre_ri_writeEnable},
        32'd0);
    chk("reset_rsp", ri_rsp_data, 32'd0);
    chk("reset_m0_addr", m0_address, 32'd0);
    rest = 1'b0;
    step();

    // Read miss, free way 2.
    fill(32'h0000_1048, 1'b1, 2'd2, 1'b0, 4'hF, 32'h0,
         32'hA0, -1, 32'h0);
    chk("t1_m0_addr", cap_addr, 32'h0000_1040);
    chk("t1_burst", {27'b0, cap_burst}, 32'd16);
    chk("t1_dw", dw, 16);
    chk("t1_dre", dre, 8);
    chk("t1_tw", tw, 1);
    chk("t1_way", {28'b0, chs}, 32'h4);
    chk("t1_tag_data", last_td, 32'h8000_0002);
    chk("t1_tag_addr", {27'b0, last_ta}, 32'd1);
    chk("t1_tag_ch", {30'b0, last_tc}, 32'd2);
    chk("t1_last_daddr", {23'b0, last_da}, 32'd31);
    chk("t1_last_dre_addr", {24'b0, last_ra}, 32'h0F);
    chk("t1_word5", wword[5], 32'hA5);
    chk("t1_rsp", rsp_last, 32'hA2);
    chk("t1_ready_cycles", rdy, 1);

    // Write miss with merge.
    fill(32'h0000_2004, 1'b1, 2'd1, 1'b1, 4'b0011, 32'h1234_5678,
         32'hB0, 1, 32'hDEAD_BEEF);
    chk("t2_dw", dw, 17);
    chk("t2_merge_addr", {23'b0, last_da}, 32'd1);
    chk("t2_merge_be", {28'b0, last_be}, 32'h3);
    chk("t2_merge_data", last_dd, 32'h1234_5678);
    chk("t2_tag_data", last_td, 32'h8000_0004);
    chk("t2_way", {28'b0, chs}, 32'h2);
    chk("t2_rsp", rsp_last, 32'hDEAD_5678);

    // No free block: round-robin victims.
    for (int k = 0; k < 5; k++) begin
      fill(32'h0000_3000 + 32'(k * 64), 1'b0, 2'd3, 1'b0, 4'hF,
           32'h0, 32'h100 * k, -1, 32'h0);
      chk($sformatf("t3_rr_way%0d", k), {28'b0, chs},
          32'd1 << exp_way[k]);
    end

    // IO write with 3 wait cycles.
    clear();
    m0_waitRequest = 1'b1;
    req_address = 32'h3000_0010;
    req_byteEnable = 4'b1100;
    req_writeData = 32'hCAFE_F00D;
    req_read = 1'b0;
    req_write = 1'b1;
    ri_cmd = C_IORW;
    ri_cmd_valid = 1'b1;
    step();
    chk("t4_m0_write", {31'b0, m0_write}, 32'd1);
    chk("t4_m0_read", {31'b0, m0_read}, 32'd0);
    chk("t4_burst", {27'b0, m0_burstCount}, 32'd1);
    chk("t4_addr", m0_address, 32'h3000_0010);
    chk("t4_be", {28'b0, m0_byteEnable}, 32'hC);
    chk("t4_wd", m0_writeData, 32'hCAFE_F00D);
    repeat (3) step();
    m0_waitRequest = 1'b0;
    wait_ready();
    chk("t4_wcyc", wcyc, 4);
    chk("t4_dw", dw, 0);
    chk("t4_tw", tw, 0);
    chk("t4_rdy", rdy, 1);

    // rb with cache disabled: single-beat read.
    clear();
    req_address = 32'h0000_4444;
    req_byteEnable = 4'hF;
    req_read = 1'b1;
    req_write = 1'b0;
    ri_isCacheEnable = 1'b0;
    ri_cmd = C_RB;
    ri_cmd_valid = 1'b1;
    wait_mread();
    chk("t5_burst", {27'b0, cap_burst}, 32'd1);
    chk("t5_addr", cap_addr, 32'h0000_4444);
    step();
    m0_readDataValid = 1'b1;
    m0_readData = 32'h5555_AAAA;
    step();
    m0_readDataValid = 1'b0;
    wait_ready();
    chk("t5_rsp", rsp_last, 32'h5555_AAAA);
    chk("t5_dw", dw, 0);
    chk("t5_tw", tw, 0);
    ri_isCacheEnable = 1'b1;

    // Reset after beat 7; valid dropped mid-operation.
    clear();
    req_address = 32'h0000_0100;
    req_read = 1'b1;
    req_write = 1'b0;
    tag_ri_isHaveFreeBlock = 1'b1;
    tag_ri_freeBlockNum = 2'd3;
    ri_cmd = C_RB;
    ri_cmd_valid = 1'b1;
    wait_mread();
    ri_cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      m0_readDataValid = 1'b1;
      m0_readData = 32'hC0 + i;
      step();
    end
    rest = 1'b1;
    m0_readData = 32'hC8;
    step();
    chk("t6_strobes_after_rst", {26'b0, ri_cmd_ready, m0_read,
        m0_write, data_ri_writeEnable, tag_ri_writeEnable,
        dre_ri_writeEnable}, 32'd0);
    rest = 1'b0;
    for (int i = 9; i < 16; i++) begin
      m0_readData = 32'hC0 + i;
      step();
    end
    m0_readDataValid = 1'b0;
    repeat (3) step();
    chk("t6_dw", dw, 8);
    chk("t6_dre", dre, 4);
    chk("t6_tw", tw, 0);
    chk("t6_rdy", rdy, 0);
    chk("t6_way", {28'b0, chs}, 32'h8);

    // nop completes with zero data.
    clear();
    ri_cmd = C_NOP;
    ri_cmd_valid = 1'b1;
    wait_ready();
    chk("t7_nop_rsp", rsp_last, 32'd0);
    chk("t7_nop_rdy", rdy, 1);

    // Normal fill after the mid-burst reset.
    fill(32'h0000_1048, 1'b1, 2'd0, 1'b0, 4'hF, 32'h0,
         32'hE0, -1, 32'h0);
    chk("t8_rsp", rsp_last, 32'hE2);
    chk("t8_dw", dw, 16);
    chk("t8_way", {28'b0, chs}, 32'h1);
    chk("t8_tw", tw, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
